xor_using_mux: RTL and testbench
================================

# xor_using_mux

Bitwise XOR built purely from 2:1 multiplexer primitives. It serves as a teaching and reference block for mux-based logic synthesis in the digital-design lab set. It provides:
- a combinational XOR output, `F`;
- a registered copy of that output, `F_q`;
- a registered parity of the result, `P_q`, built from a mux chain.

Downstream logic can use either the zero-latency or the one-cycle-latency result.

## Interface
Parameters:
- `WIDTH`, default 1: operand width in bits; legal range 1–32.

Ports:
- `clk`  input  1: single clock. All state updates on the rising edge.
- `rst`  input  1: reset, synchronous and active-high. Clears all registered outputs.
- `A`  input  WIDTH: operand A. Drives the mux select of each bit slice.
- `B`  input  WIDTH: operand B. Drives the mux data inputs of each bit slice.
- `F`  output  WIDTH: combinational result, A XOR B.
- `F_q`  output  WIDTH: F registered once.
- `P_q`  output  1: registered even-parity (XOR-reduction) of F.

## Operation
- Each bit i is one 2:1 mux cell: select = `A[i]`, in0 = `B[i]`, in1 = `~B[i]`, out = `F[i]`.
  - Truth table: (A,B) = 00→0, 01→1, 10→1, 11→0.
- `~B[i]` is itself a mux cell: select = `B[i]`, in0 = 1, in1 = 0. No `^` operator is permitted in the datapath.
- `WIDTH` slices are instantiated with a generate loop. A shared mux-cell submodule is allowed, provided its name is distinct from `xor_using_mux`.
- Parity is a linear chain of WIDTH−1 mux-XOR cells over `F[0]..F[WIDTH-1]`.
  - Chain node 0 = `F[0]`.
  - Node k = mux(select = node k−1, in0 = `F[k]`, in1 = `~F[k]`).
  - For WIDTH = 1, parity = `F[0]`.
- Register update, on each rising edge:
  - `rst` = 1: `F_q` ← 0 and `P_q` ← 0.
  - Otherwise: `F_q` ← `F` and `P_q` ← chain output.
- `F` does not depend on `clk` or `rst`. It is valid whenever `A` and `B` are valid, including during reset.
- X or Z on a select propagates per standard mux semantics. No X-masking logic.

## Timing
- `F`: combinational. Zero cycles of latency; settles within one propagation delay of any input change.
- `F_q` and `P_q`: latency of exactly one cycle. The value sampled at edge n reflects `A`/`B` stable before edge n.
- Reset value of every output:
  - `F_q` = 0 and `P_q` = 0 from the first edge with `rst` high.
  - Before that first reset edge, both are X.
  - `F` carries no reset value.
- Reset mid-operation: the edge on which `rst` = 1 clears `F_q`/`P_q` regardless of inputs.
- Reset release: the first edge with `rst` = 0 loads the current `F`.
- Simultaneous input change and clock edge: inputs must meet setup to the edge. No internal synchronisation is provided.

## Test plan
- Exhaustive 1-bit combinational check (WIDTH = 1, `rst` held low): apply (A,B) = 00, 01, 10, 11, each held 10 ns. `F` must read 0, 1, 1, 0 at every sample.
- Registered path (WIDTH = 1): after reset, apply A=1, B=0 before an edge. `F_q` = 1 and `P_q` = 1 after that edge. Then A=1, B=1: `F_q` = 0 and `P_q` = 0 on the next edge.
- Reset dominance: with A=1, B=0 held and `F_q` = 1, assert `rst` for one edge. `F_q` = 0 and `P_q` = 0 at that edge, while `F` stays 1 throughout. Release `rst`: `F_q` = 1 on the next edge.
- Vector operation (WIDTH = 8): A=0xA5, B=0x3C. `F` = 0x99 immediately. After one edge, `F_q` = 0x99 and `P_q` = 0 (four ones).
- Parity odd case (WIDTH = 8): A=0xFF, B=0xFE. `F` = 0x01; after one edge, `F_q` = 0x01 and `P_q` = 1.
- Randomised sweep (WIDTH = 32): 1000 random A/B pairs.
  - Compare `F` against a reference XOR model every cycle.
  - Compare `F_q` and `P_q` against the one-cycle-delayed model.
  - Zero mismatches allowed.

Source files
------------

// File: rtl/xor_using_mux.sv
// Bitwise XOR built only from 2:1 mux cells, with a registered copy of the
// result and a registered parity computed through a linear mux-XOR chain.

module mux2_cell (
  input  logic sel,
  input  logic in0,
  input  logic in1,
  output logic y
);
  assign y = sel ? in1 : in0;
endmodule

module xor_using_mux #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] F,
  output logic [WIDTH-1:0] F_q,
  output logic             P_q
);

  logic [WIDTH-1:0] node;
  logic [WIDTH-1:0] f_d;
  logic             p_d;
  logic [WIDTH-1:0] f_q;
  logic             p_q;

  // Each slice: invert B with a mux, then let A pick between B and ~B.
  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    logic nb;
    mux2_cell u_inv (.sel(B[i]), .in0(1'b1), .in1(1'b0), .y(nb));
    mux2_cell u_xor (.sel(A[i]), .in0(B[i]), .in1(nb),   .y(F[i]));
  end

  assign node[0] = F[0];

  for (genvar k = 1; k < WIDTH; k++) begin : g_par
    logic nf;
    mux2_cell u_inv (.sel(F[k]),      .in0(1'b1), .in1(1'b0), .y(nf));
    mux2_cell u_xor (.sel(node[k-1]), .in0(F[k]), .in1(nf),   .y(node[k]));
  end

  assign f_d = F;
  assign p_d = node[WIDTH-1];

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      f_q <= '0;
      p_q <= 1'b0;
    end else begin
      f_q <= f_d;
      p_q <= p_d;
    end
  end

  assign F_q = f_q;
  assign P_q = p_q;

endmodule

// File: tb/tb_xor_using_mux.sv
// Self-checking bench for xor_using_mux at WIDTH = 1, 8 and 32.

module tb_xor_using_mux;

  logic        clk;
  logic        rst;
  logic [0:0]  a1, b1, f1, fq1;
  logic        pq1;
  logic [7:0]  a8, b8, f8, fq8;
  logic        pq8;
  logic [31:0] a32, b32, f32, fq32;
  logic        pq32;

  int n_checks;
  int n_errors;

  xor_using_mux #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .A(a1), .B(b1), .F(f1), .F_q(fq1), .P_q(pq1)
  );
  xor_using_mux #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .F(f8), .F_q(fq8), .P_q(pq8)
  );
  xor_using_mux #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .A(a32), .B(b32), .F(f32), .F_q(fq32), .P_q(pq32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_xor(input logic [31:0] a, input logic [31:0] b);
    return a ^ b;
  endfunction

  function automatic logic ref_par(input logic [31:0] v);
    return ($countones(v) % 2) == 1;
  endfunction

  initial begin
    logic [31:0] exp_f, prev_f;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    a1 = '0; b1 = '0; a8 = '0; b8 = '0; a32 = '0; b32 = '0;

    repeat (2) @(negedge clk);
    chk("rst_fq1", fq1, 0);
    chk("rst_pq1", pq1, 0);
    chk("rst_fq8", fq8, 0);
    chk("rst_fq32", fq32, 0);
    chk("rst_pq32", pq32, 0);

    rst = 1'b0;
    // 1-bit exhaustive: combinational and registered
    for (int v = 0; v < 4; v++) begin
      {a1, b1} = v[1:0];
      #2;
      chk("f1_comb", f1, (v == 1 || v == 2) ? 1 : 0);
      @(negedge clk);
      chk("f1_hold", f1, (v == 1 || v == 2) ? 1 : 0);
      chk("fq1_reg", fq1, (v == 1 || v == 2) ? 1 : 0);
      chk("pq1_reg", pq1, (v == 1 || v == 2) ? 1 : 0);
    end

    a1 = 1'b1; b1 = 1'b0;
    @(negedge clk);
    chk("fq1_pre_rst", fq1, 1);
    rst = 1'b1;
    #2;
    chk("f1_in_rst_a", f1, 1);
    @(negedge clk);
    chk("fq1_rst_dom", fq1, 0);
    chk("pq1_rst_dom", pq1, 0);
    chk("f1_in_rst_b", f1, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("fq1_release", fq1, 1);
    chk("pq1_release", pq1, 1);

    a8 = 8'hA5; b8 = 8'h3C;
    #1;
    chk("f8_vec", f8, 32'h99);
    @(negedge clk);
    chk("fq8_vec", fq8, 32'h99);
    chk("pq8_even", pq8, 0);
    a8 = 8'hFF; b8 = 8'hFE;
    #1;
    chk("f8_odd", f8, 32'h01);
    @(negedge clk);
    chk("fq8_odd", fq8, 32'h01);
    chk("pq8_odd", pq8, 1);

    // 32-bit randomised sweep against the reference model
    prev_f = '0;
    for (int n = 0; n < 1000; n++) begin
      a32 = $urandom;
      b32 = $urandom;
      exp_f = ref_xor(a32, b32);
      #1;
      chk("f32_rand", f32, exp_f);
      if (n > 0) begin
        chk("fq32_rand", fq32, prev_f);
        chk("pq32_rand", {31'b0, pq32}, {31'b0, ref_par(prev_f)});
      end
      prev_f = exp_f;
      @(negedge clk);
    end
    chk("fq32_last", fq32, prev_f);
    chk("pq32_last", {31'b0, pq32}, {31'b0, ref_par(prev_f)});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
